// File: rtl/fp_mul_pkg.sv
// Shared constants and FSM encoding for the FP multiplier dispatcher.
// Flag bit positions match the multiplier's {OF,UF,NaNF,InfF,DNF,ZF} bus, with TO added on top.
package fp_mul_pkg;

   localparam int FLAG_W   = 6;
   localparam int FLG_ZF   = 0;
   localparam int FLG_DNF  = 1;
   localparam int FLG_INFF = 2;
   localparam int FLG_NANF = 3;
   localparam int FLG_UF   = 4;
   localparam int FLG_OF   = 5;
   localparam int FLG_TO   = 6;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      ST_SETTLE = 3'd0,
      ST_IDLE   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_BUSY   = 3'd3,
      ST_GAP    = 3'd4
   } state_e;

endpackage

// File: rtl/fp_mul_opq.sv
// Operand queue: synchronous FIFO of {tag, b, a} entries with an occupancy count.
// Pushes are refused when full and pops when empty, so callers may be sloppy with either.
module fp_mul_opq #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 68,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [AW:0]      count_o
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      count_q;
   logic             pushOk;
   logic             popOk;

   assign pushOk  = push_i && (count_q < DEPTH_C);
   assign popOk   = pop_i && (count_q != '0);
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   // Storage carries no reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge Clk) begin
      if (pushOk) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (pushOk) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (popOk) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case ({pushOk, popOk})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fp_mul_dispatch.sv
// Sequencer around the multi-cycle FP multiplier: queues operand pairs, issues one Start at a time,
// and holds each result until consumed. Build with FP_MUL_DISPATCH_TIMEOUT_EN to add a BUSY watchdog.
module fp_mul_dispatch
   import fp_mul_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int SETTLE  = 2,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              mul_start,
   output logic [31:0]       mul_a,
   output logic [31:0]       mul_b,
   input  logic              mul_done,
   input  logic [31:0]       mul_p,
   input  logic [FLAG_W-1:0] mul_flags,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_p,
   output logic [FLAG_W:0]   out_flags,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   localparam int AW      = $clog2(DEPTH);
   localparam int EW      = TAG_W + 64;
   localparam int CNT_MAX = (SETTLE > GAP) ? SETTLE : GAP;
   localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W < 1 || TIMEOUT < 1) begin : gBadParams
      $error("fp_mul_dispatch: illegal parameter set");
   end

   state_e            stateQ, stateD;
   logic [CW-1:0]     cntQ, cntD;
   logic [31:0]       mulAQ, mulAD;
   logic [31:0]       mulBQ, mulBD;
   logic [TAG_W-1:0]  tagQ, tagD;
   logic              outValidQ, outValidD;
   logic [31:0]       outPQ, outPD;
   logic [FLAG_W:0]   outFlagsQ, outFlagsD;
   logic [TAG_W-1:0]  outTagQ, outTagD;

   logic [EW-1:0]     fifoHead;
   logic [AW:0]       fifoCount;
   logic              fifoPush;
   logic              fifoPop;
   logic              slotFree;

`ifdef FP_MUL_DISPATCH_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
   logic [WW-1:0]     wdQ, wdD;
   logic [FLAG_W:0]   toFlags;
`endif

   fp_mul_opq #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) uOpq (
      .Clk     (Clk),
      .Rst     (Rst),
      .push_i  (fifoPush),
      .pop_i   (fifoPop),
      .wdata_i ({in_tag, in_b, in_a}),
      .rdata_o (fifoHead),
      .count_o (fifoCount)
   );

   assign in_ready  = (fifoCount < DEPTH_C);
   assign fifoPush  = in_valid && in_ready;
   assign slotFree  = !outValidQ || out_ready;
   assign mul_start = (stateQ == ST_ISSUE);
   assign mul_a     = mulAQ;
   assign mul_b     = mulBQ;
   assign out_valid = outValidQ;
   assign out_p     = outPQ;
   assign out_flags = outFlagsQ;
   assign out_tag   = outTagQ;
   assign busy      = (fifoCount != '0) || (stateQ == ST_ISSUE) || (stateQ == ST_BUSY) || outValidQ;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stateQ    <= ST_SETTLE;
         cntQ      <= CW'(SETTLE);
         mulAQ     <= '0;
         mulBQ     <= '0;
         tagQ      <= '0;
         outValidQ <= 1'b0;
         outPQ     <= '0;
         outFlagsQ <= '0;
         outTagQ   <= '0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         mulAQ     <= mulAD;
         mulBQ     <= mulBD;
         tagQ      <= tagD;
         outValidQ <= outValidD;
         outPQ     <= outPD;
         outFlagsQ <= outFlagsD;
         outTagQ   <= outTagD;
      end
   end

`ifdef FP_MUL_DISPATCH_TIMEOUT_EN
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wdQ <= '0;
      end else begin
         wdQ <= wdD;
      end
   end
`endif

   // Operands track the FIFO head only in IDLE, so they stay frozen from ISSUE until the result lands.
   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      mulAD     = mulAQ;
      mulBD     = mulBQ;
      tagD      = tagQ;
      outValidD = outValidQ && !out_ready;
      outPD     = outPQ;
      outFlagsD = outFlagsQ;
      outTagD   = outTagQ;
      fifoPop   = 1'b0;
`ifdef FP_MUL_DISPATCH_TIMEOUT_EN
      wdD       = wdQ;
      toFlags   = '0;
      toFlags[FLG_TO]   = 1'b1;
      toFlags[FLG_NANF] = 1'b1;
`endif
      case (stateQ)
         ST_SETTLE, ST_GAP: begin
            if (cntQ == '0) begin
               stateD = ST_IDLE;
            end else begin
               cntD = cntQ - 1'b1;
            end
         end
         ST_IDLE: begin
            mulAD = fifoHead[31:0];
            mulBD = fifoHead[63:32];
            tagD  = fifoHead[64 +: TAG_W];
            if ((fifoCount != '0) && slotFree) begin
               stateD = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            fifoPop = 1'b1;
            stateD  = ST_BUSY;
`ifdef FP_MUL_DISPATCH_TIMEOUT_EN
            wdD     = '0;
`endif
         end
         ST_BUSY: begin
            if (mul_done) begin
               outPD     = mul_p;
               outFlagsD = {1'b0, mul_flags};
               outTagD   = tagQ;
               outValidD = 1'b1;
               cntD      = CW'(GAP);
               stateD    = ST_GAP;
            end
`ifdef FP_MUL_DISPATCH_TIMEOUT_EN
            else if (wdQ == WD_LAST) begin
               outPD     = QNAN;
               outFlagsD = toFlags;
               outTagD   = tagQ;
               outValidD = 1'b1;
               cntD      = CW'(GAP);
               stateD    = ST_GAP;
            end else begin
               wdD = wdQ + 1'b1;
            end
`endif
         end
         default: begin
            stateD = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fp_mul_dispatch.sv
// Randomized bench for fp_mul_dispatch: a behavioural multiplier stub answers Start pulses and
// a result queue built from pushed operands predicts every output transaction in order.
module tb_fp_mul_dispatch;
   import fp_mul_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int SETTLE  = 2;
   localparam int GAP     = 2;
   localparam int TIMEOUT = 32;

   typedef struct {
      logic [31:0]      p;
      logic [6:0]       flags;
      logic [TAG_W-1:0] tag;
   } res_t;

   logic              Clk = 1'b0;
   logic              Rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_a = '0;
   logic [31:0]       in_b = '0;
   logic [TAG_W-1:0]  in_tag = '0;
   logic              mul_start;
   logic [31:0]       mul_a, mul_b;
   logic              mul_done = 1'b0;
   logic [31:0]       mul_p = '0;
   logic [5:0]        mul_flags = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_p;
   logic [6:0]        out_flags;
   logic [TAG_W-1:0]  out_tag;
   logic              busy;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   res_t expQ[$];

   bit          stubBusy = 0;
   bit          stubMute = 0;
   int          stubLat = 0;
   int          fixedLat = 0;
   logic [31:0] heldA, heldB;
   int          lastDoneCyc = -100;
   int          relCyc = 0;
   int          startCount = 0;
   int          doneCount = 0;
   logic [31:0] lastP;
   logic [6:0]  lastFlags;
   logic [TAG_W-1:0] lastTag;
   int          lastResCyc = 0;
   bit          prodDone;

   fp_mul_dispatch #(
      .DEPTH(DEPTH), .TAG_W(TAG_W), .SETTLE(SETTLE), .GAP(GAP), .TIMEOUT(TIMEOUT)
   ) dut (
      .Clk(Clk), .Rst(Rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_p(mul_p), .mul_flags(mul_flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags),
      .out_tag(out_tag), .busy(busy)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Truncating single-precision product with denormals treated as zero; returns {flags, p}.
   function automatic logic [37:0] refMul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          ea, eb, e;
      logic [47:0] prod;
      logic [22:0] mant;
      logic [5:0]  f;
      logic [31:0] p;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      f  = '0;
      p  = '0;
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) begin
         p = QNAN;
         f[FLG_NANF] = 1'b1;
      end else if (ea == 255 || eb == 255) begin
         p = {s, 8'hFF, 23'h0};
         f[FLG_INFF] = 1'b1;
      end else if (ea == 0 || eb == 0) begin
         p = {s, 31'h0};
         f[FLG_ZF] = 1'b1;
      end else begin
         prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
         e = ea + eb - 127;
         if (prod[47]) begin
            mant = prod[46:24];
            e++;
         end else begin
            mant = prod[45:23];
         end
         if (e >= 255) begin
            p = {s, 8'hFF, 23'h0};
            f[FLG_OF] = 1'b1;
            f[FLG_INFF] = 1'b1;
         end else if (e <= 0) begin
            p = {s, 31'h0};
            f[FLG_UF] = 1'b1;
            f[FLG_ZF] = 1'b1;
         end else begin
            p = {s, e[7:0], mant};
         end
      end
      return {f, p};
   endfunction

   function automatic logic [31:0] randOp();
      int sel;
      sel = $urandom_range(0, 15);
      if (sel == 0) return {1'($urandom), 31'h0};
      if (sel == 1) return {1'($urandom), 8'hFF, 23'h0};
      if (sel == 2) return QNAN;
      return {1'($urandom), 8'($urandom_range(80, 175)), 23'($urandom)};
   endfunction

   // Multiplier stub: answers each Start after a few cycles and polices Start timing rules.
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         mul_done = 1'b0;
         if (Rst) begin
            stubBusy = 0;
            continue;
         end
         if (stubBusy) begin
            checkOutput("mulAHeld", mul_a, heldA);
            checkOutput("mulBHeld", mul_b, heldB);
            stubLat--;
            if (stubLat == 0 && !stubMute) begin
               {mul_flags, mul_p} = refMul(heldA, heldB);
               mul_done = 1'b1;
               stubBusy = 0;
               lastDoneCyc = cyc;
               doneCount++;
            end
         end
         if (mul_start) begin
            checkOutput("startWhileBusy", stubBusy, 0);
            checkOutput("startAfterGap", (cyc - lastDoneCyc) > GAP, 1);
            checkOutput("startAfterSettle", (cyc - relCyc) > SETTLE, 1);
            heldA = mul_a;
            heldB = mul_b;
            stubLat = (fixedLat != 0) ? fixedLat : $urandom_range(1, 4);
            stubBusy = 1;
            startCount++;
         end
      end
   end

   always @(negedge Clk) begin : consumer
      res_t e;
      if (!Rst && out_valid && out_ready) begin
         lastP = out_p;
         lastFlags = out_flags;
         lastTag = out_tag;
         lastResCyc = cyc;
         if (expQ.size() == 0) begin
            checkOutput("unexpectedResult", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("outP", out_p, e.p);
            checkOutput("outFlags", out_flags, e.flags);
            checkOutput("outTag", out_tag, e.tag);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      logic        acc;
      int          waitCnt;
      logic [37:0] r;
      waitCnt = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_tag = tag;
      do begin
         @(negedge Clk);
         acc = in_ready;
         @(posedge Clk);
         #1;
         waitCnt++;
      end while (!acc && waitCnt < 200);
      in_valid = 1'b0;
      if (!acc) begin
         checkOutput("pushTimeout", 0, 1);
      end else begin
         r = refMul(a, b);
         expQ.push_back('{r[31:0], {1'b0, r[37:32]}, tag});
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic waitDrain(input int maxCyc);
      int n;
      n = 0;
      while ((expQ.size() != 0 || busy) && n < maxCyc) begin
         @(posedge Clk);
         #1;
         n++;
      end
      checkOutput("drained", (expQ.size() == 0) && !busy, 1);
   endtask

   task automatic checkResetState();
      @(negedge Clk);
      checkOutput("rstOutValid", out_valid, 0);
      checkOutput("rstOutP", out_p, 0);
      checkOutput("rstOutFlags", out_flags, 0);
      checkOutput("rstOutTag", out_tag, 0);
      checkOutput("rstMulStart", mul_start, 0);
      checkOutput("rstMulA", mul_a, 0);
      checkOutput("rstMulB", mul_b, 0);
      checkOutput("rstBusy", busy, 0);
   endtask

   task automatic releaseReset();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      relCyc = cyc;
      lastDoneCyc = -100;
      checkOutput("rstInReady", in_ready, 1);
   endtask

   initial begin
      int s0, d0, tPush;
      $display("[TB] start");
      Rst = 1'b1;
      @(posedge Clk);
      checkResetState();
      releaseReset();

      // Single operation: 3.0 x 2.0
      out_ready = 1'b1;
      s0 = startCount;
      applyStimulus(32'h4040_0000, 32'h4000_0000, 4'd3);
      waitDrain(100);
      checkOutput("singleStarts", startCount - s0, 1);
      checkOutput("singleP", lastP, 32'h40C0_0000);
      checkOutput("singleFlags", lastFlags, 7'h00);
      checkOutput("singleTag", lastTag, 4'd3);

      // Special operands
      applyStimulus(32'h7FC0_0000, 32'h3F80_0000, 4'd1);
      waitDrain(100);
      checkOutput("nanFlag", lastFlags[FLG_NANF], 1);
      applyStimulus(32'h0000_0000, 32'h3F80_0000, 4'd2);
      waitDrain(100);
      checkOutput("zeroFlag", lastFlags[FLG_ZF], 1);
      checkOutput("zeroP", lastP, 32'h0);

      // Back-pressure with a stalled consumer
      out_ready = 1'b0;
      d0 = doneCount;
      for (int i = 0; i < 5; i++) applyStimulus(randOp(), randOp(), TAG_W'(i));
      stepCycles(20);
      checkOutput("bpInReady", in_ready, 0);
      checkOutput("bpOneResult", doneCount - d0, 1);
      checkOutput("bpOutValid", out_valid, 1);
      out_ready = 1'b1;
      applyStimulus(randOp(), randOp(), 4'd5);
      waitDrain(300);
      checkOutput("bpAllDone", doneCount - d0, 6);

      // Streamed ops with fixed short latency, then random traffic with random back-pressure
      fixedLat = 1;
      for (int i = 0; i < 3; i++) applyStimulus(randOp(), randOp(), TAG_W'(i + 8));
      waitDrain(200);
      fixedLat = 0;
      prodDone = 0;
      fork
         begin
            for (int i = 0; i < 24; i++) applyStimulus(randOp(), randOp(), TAG_W'(i));
            prodDone = 1;
         end
         begin
            while (!prodDone) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge Clk);
               #1;
            end
         end
      join
      out_ready = 1'b1;
      waitDrain(2000);

      // Reset while the multiplier is busy
      fixedLat = 20;
      s0 = startCount;
      applyStimulus(randOp(), randOp(), 4'd9);
      for (int n = 0; n < 50 && startCount == s0; n++) stepCycles(1);
      checkOutput("rstBusyStarted", startCount - s0, 1);
      stepCycles(3);
      Rst = 1'b1;
      expQ.delete();
      checkResetState();
      releaseReset();
      fixedLat = 0;
      applyStimulus(32'h4040_0000, 32'h4000_0000, 4'd6);
      waitDrain(100);
      checkOutput("postRstP", lastP, 32'h40C0_0000);
      checkOutput("postRstTag", lastTag, 4'd6);

`ifdef FP_MUL_DISPATCH_TIMEOUT_EN
      stubMute = 1;
      applyStimulus(32'h4040_0000, 32'h4000_0000, 4'd7);
      tPush = cyc;
      void'(expQ.pop_back());
      expQ.push_back('{QNAN, 7'h48, 4'd7});
      waitDrain(TIMEOUT + 40);
      stubMute = 0;
      stubBusy = 0;
      checkOutput("toP", lastP, QNAN);
      checkOutput("toFlagTO", lastFlags[FLG_TO], 1);
      checkOutput("toFlagNaN", lastFlags[FLG_NANF], 1);
      checkOutput("toLate", (lastResCyc - tPush) >= TIMEOUT, 1);
`else
      tPush = 0;
      checkOutput("toTiedLow", lastFlags[FLG_TO], tPush[0]);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
